acc_writeback: RTL and testbench

ACC_WRITEBACK -- requirements
Module: acc_writeback

---
 rtl/acc_writeback.sv | 128 ++++++++++++
 tb/tb_acc_writeback.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/acc_writeback.sv
// Coefficient write-back: reduces accumulated coefficients mod KEM_Q and writes them
// into two interleaved memory banks (even/odd index) through a single register stage.
module acc_writeback #(
   parameter int KEM_Q  = 7681,
   parameter int N_COEF = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        coef_valid,
   input  logic [15:0] coef_in,
   output logic        coef_ready,
   output logic        mem_we0,
   output logic        mem_we1,
   output logic [4:0]  mem_wr_addr,
   output logic [15:0] mem_wr_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  dbg_state
);

   // Handshake: a coefficient transfers on a rising edge where coef_valid and
   // coef_ready are both 1; coef_ready is high only in RUN and abort blocks the transfer.

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [16:0] Q1     = 17'(KEM_Q);
   localparam logic [16:0] Q2     = 17'(2 * KEM_Q);
   localparam logic [5:0]  LAST_I = 6'(N_COEF - 1);

   logic [1:0]  state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic        we_q, we_d;
   logic        bank_q, bank_d;
   logic [4:0]  addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        err_q, err_d;

   logic        xfer;
   logic        out_of_range;
   logic [15:0] reduced;
   logic [16:0] coef_ext;

   always_comb begin
      coef_ext     = {1'b0, coef_in};
      out_of_range = 1'b0;
      reduced      = coef_in;
      if (coef_ext >= Q2) begin
         out_of_range = 1'b1;
         reduced      = 16'd0;
      end else if (coef_ext >= Q1) begin
         reduced = 16'(coef_ext - Q1);
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      we_d    = 1'b0;
      bank_d  = bank_q;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = err_q;
      xfer    = (state_q == RUN) && coef_valid && !abort;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               idx_d   = 6'd0;
               err_d   = 1'b0;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (xfer) begin
               we_d   = 1'b1;
               bank_d = idx_q[0];
               addr_d = idx_q[5:1];
               data_d = reduced;
               idx_d  = idx_q + 6'd1;
               if (out_of_range) err_d = 1'b1;
               if (idx_q == LAST_I) state_d = FLUSH;
            end
         end
         // The last write is on the bus during FLUSH; DONE follows once it is issued.
         FLUSH: state_d = abort ? IDLE : DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 6'd0;
         we_q    <= 1'b0;
         bank_q  <= 1'b0;
         addr_q  <= 5'd0;
         data_q  <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign coef_ready  = (state_q == RUN);
   assign mem_we0     = we_q && !bank_q;
   assign mem_we1     = we_q && bank_q;
   assign mem_wr_addr = addr_q;
   assign mem_wr_data = data_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign err         = err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_acc_writeback.sv
// Directed bench for acc_writeback: reduction table, full passes, bubbles, abort,
// mid-pass reset and start-while-busy, all with hand-computed expectations.
module tb_acc_writeback;

   logic        clk = 1'b0;
   logic        rst, start, abort, coef_valid;
   logic [15:0] coef_in;
   logic        coef_ready, mem_we0, mem_we1, busy, done, err;
   logic [4:0]  mem_wr_addr;
   logic [15:0] mem_wr_data;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;

   acc_writeback dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .coef_valid(coef_valid), .coef_in(coef_in), .coef_ready(coef_ready),
      .mem_we0(mem_we0), .mem_we1(mem_we1), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .busy(busy), .done(done), .err(err),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] coef;
      logic [15:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Transfer one coefficient and check the write that must follow one cycle later.
   task automatic do_xfer(input logic [15:0] val, input logic [15:0] exp_data, input logic [5:0] idx);
      coef_valid = 1'b1;
      coef_in    = val;
      @(posedge clk); #1;
      coef_valid = 1'b0;
      if (mem_we0 || mem_we1) wr_cnt++;
      chk("we0", mem_we0, idx[0] == 1'b0);
      chk("we1", mem_we1, idx[0]);
      chk("addr", mem_wr_addr, idx[5:1]);
      chk("data", mem_wr_data, exp_data);
   endtask

   task automatic idle_cycle(input string nm);
      coef_valid = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_no_we"}, mem_we0 | mem_we1, 0);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_ready", coef_ready, 1);
   endtask

   task automatic do_abort();
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_idle", busy, 0);
   endtask

   initial begin
      tbl[0] = '{16'd7680,  16'd7680, 1'b0};
      tbl[1] = '{16'd7681,  16'd0,    1'b0};
      tbl[2] = '{16'd15361, 16'd7680, 1'b0};
      tbl[3] = '{16'd0,     16'd0,    1'b0};
      tbl[4] = '{16'd100,   16'd100,  1'b0};
      tbl[5] = '{16'd15362, 16'd0,    1'b1};

      rst = 1'b1; start = 1'b0; abort = 1'b0; coef_valid = 1'b0; coef_in = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_ready", coef_ready, 0);
      chk("rst_we", mem_we0 | mem_we1, 0);
      chk("rst_addr", mem_wr_addr, 0);
      chk("rst_data", mem_wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);

      // Full pass with value=index; a stray start mid-pass must be ignored.
      do_start();
      wr_cnt = 0;
      for (int k = 0; k < 64; k++) begin
         if (k == 20) start = 1'b1;
         do_xfer(16'(k), 16'(k), 6'(k));
         start = 1'b0;
         if (k < 63) chk("run_done_low", done, 0);
      end
      chk("flush_ready", coef_ready, 0);
      chk("flush_busy", busy, 1);
      idle_cycle("done_cyc");
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      idle_cycle("after_done");
      chk("done_cleared", done, 0);
      chk("idle_busy", busy, 0);
      chk("write_count", wr_cnt, 64);
      chk("pass_err", err, 0);
      chk("hold_addr", mem_wr_addr, 31);
      chk("hold_data", mem_wr_data, 63);

      // Reduction table at the head of a pass, remainder value=index.
      do_start();
      for (int i = 0; i < 6; i++) begin
         do_xfer(tbl[i].coef, tbl[i].exp_data, 6'(i));
         chk("tbl_err", err, tbl[i].exp_err);
      end
      for (int k = 6; k < 64; k++) do_xfer(16'(k), 16'(k), 6'(k));
      idle_cycle("red_done");
      chk("red_done_pulse", done, 1);
      chk("err_after_done", err, 1);
      idle_cycle("red_idle");
      chk("err_sticky_idle", err, 1);
      do_start();
      chk("start_clears_err", err, 0);
      do_abort();

      // Bubbles: valid 1,0,0,1.
      do_start();
      do_xfer(16'd11, 16'd11, 6'd0);
      idle_cycle("bubble1");
      idle_cycle("bubble2");
      do_xfer(16'd22, 16'd22, 6'd1);
      idle_cycle("bubble_tail");
      do_abort();

      // Abort alongside the 10th transfer.
      do_start();
      for (int k = 0; k < 9; k++) do_xfer(16'(k + 1000), 16'(k + 1000), 6'(k));
      coef_valid = 1'b1; coef_in = 16'd4321; abort = 1'b1;
      @(posedge clk); #1;
      coef_valid = 1'b0; abort = 1'b0;
      chk("abort_no_we", mem_we0 | mem_we1, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", coef_ready, 0);
      idle_cycle("abort_after");
      chk("abort_no_done", done, 0);
      do_start();
      do_xfer(16'd500, 16'd500, 6'd0);
      do_abort();

      // Reset mid-pass with a write pending.
      do_start();
      do_xfer(16'd5, 16'd5, 6'd0);
      coef_valid = 1'b1; coef_in = 16'd6; rst = 1'b1;
      @(posedge clk); #1;
      coef_valid = 1'b0; rst = 1'b0;
      chk("mrst_we", mem_we0 | mem_we1, 0);
      chk("mrst_addr", mem_wr_addr, 0);
      chk("mrst_data", mem_wr_data, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_ready", coef_ready, 0);
      chk("mrst_done", done, 0);
      chk("mrst_err", err, 0);
      idle_cycle("mrst_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
